ddr3_port_arbiter: RTL and testbench

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

---
 rtl/ddr3_port_arbiter_pkg.sv | 47 ++++
 rtl/ddr3_port_arbiter_fifo.sv | 52 +++++
 rtl/ddr3_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_port_arbiter_pkg.sv
// Shared definitions for the DDR3 two-port command arbiter:
// host command encodings, return-tag layout and burst sizing helpers.
package ddr3_port_arbiter_pkg;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_SCR = 3'd1;
    localparam logic [2:0] CMD_SCW = 3'd2;
    localparam logic [2:0] CMD_BLR = 3'd3;
    localparam logic [2:0] CMD_BLW = 3'd4;
    localparam logic [2:0] CMD_ATR = 3'd5;
    localparam logic [2:0] CMD_ATW = 3'd6;

    localparam int WORDS_W = 6;
    localparam int TAG_W   = 1 + WORDS_W;

    // Controller write FIFO holds 32 words.
    localparam logic [6:0] FILL_LIMIT = 7'd32;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } arb_state_e;

    typedef struct packed {
        logic               port;
        logic [WORDS_W-1:0] words;
    } tag_t;

    function automatic logic [WORDS_W-1:0] cmd_beats(
        input logic [2:0] cmd,
        input logic [1:0] sz
    );
        if (cmd == CMD_BLW || cmd == CMD_BLR) begin
            return {1'b0, sz, 3'b000} + 6'd8;
        end
        return 6'd1;
    endfunction

    function automatic logic is_write(input logic [2:0] cmd);
        return cmd == CMD_SCW || cmd == CMD_ATW || cmd == CMD_BLW;
    endfunction

    function automatic logic is_read(input logic [2:0] cmd);
        return cmd == CMD_SCR || cmd == CMD_ATR || cmd == CMD_BLR;
    endfunction

endpackage

// File: rtl/ddr3_port_arbiter_fifo.sv
// Show-ahead FIFO holding return tags for outstanding reads.
// Head entry is visible on dout_o whenever empty_o is low.
module ddr3_port_arbiter_fifo #(
    parameter int DEPTH_P2 = 4,
    parameter int WIDTH    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int DEPTH = 1 << DEPTH_P2;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_P2:0] wr_q;
    logic [DEPTH_P2:0] rd_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[DEPTH_P2] != rd_q[DEPTH_P2]) &&
                     (wr_q[DEPTH_P2-1:0] == rd_q[DEPTH_P2-1:0]);
    assign dout_o  = mem_q[rd_q[DEPTH_P2-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[DEPTH_P2-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin arbiter in front of a DDR3 controller host port.
// Issues commands, streams write bursts and steers read returns by tag.
module ddr3_port_arbiter
    import ddr3_port_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH_P2 = 4,
    parameter int NPORT        = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_valid,
    input  logic [2:0]  p0_cmd,
    input  logic [25:0] p0_addr,
    input  logic [1:0]  p0_sz,
    input  logic [2:0]  p0_op,
    input  logic [15:0] p0_din,
    output logic        p0_accept,
    output logic        p0_wready,
    output logic        p0_rvalid,
    output logic [15:0] p0_rdata,
    output logic [25:0] p0_raddr,
    input  logic        p0_rready,

    input  logic        p1_valid,
    input  logic [2:0]  p1_cmd,
    input  logic [25:0] p1_addr,
    input  logic [1:0]  p1_sz,
    input  logic [2:0]  p1_op,
    input  logic [15:0] p1_din,
    output logic        p1_accept,
    output logic        p1_wready,
    output logic        p1_rvalid,
    output logic [15:0] p1_rdata,
    output logic [25:0] p1_raddr,
    input  logic        p1_rready,

    output logic [2:0]  ctl_cmd,
    output logic [25:0] ctl_addr,
    output logic [1:0]  ctl_sz,
    output logic [2:0]  ctl_op,
    output logic [15:0] ctl_din,
    output logic        ctl_read,
    input  logic        ctl_ready,
    input  logic        ctl_notfull,
    input  logic        ctl_validout,
    input  logic [5:0]  ctl_fillcount,
    input  logic [15:0] ctl_dout,
    input  logic [25:0] ctl_raddr
);

    logic [NPORT-1:0]        valid_v;
    logic [NPORT-1:0][2:0]   cmd_v;
    logic [NPORT-1:0][25:0]  addr_v;
    logic [NPORT-1:0][1:0]   sz_v;
    logic [NPORT-1:0][2:0]   op_v;
    logic [NPORT-1:0][15:0]  din_v;
    logic [NPORT-1:0]        rready_v;

    logic [NPORT-1:0]        ok_v;
    logic [NPORT-1:0]        elig_v;
    logic [NPORT-1:0]        accept_v;
    logic [NPORT-1:0]        wready_v;
    logic [NPORT-1:0]        rvalid_v;

    arb_state_e              state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    bport_q, bport_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [WORDS_W-1:0]      used_q, used_d;
    logic                    rblk_q;

    logic                    win;
    logic                    issue;
    logic [WORDS_W-1:0]      win_beats;
    logic                    ret_ok;
    logic                    tag_push;
    logic                    tag_pop;
    logic                    tag_full;
    logic                    tag_empty;
    tag_t                    tag_in;
    tag_t                    tag_head;

    assign valid_v  = {p1_valid, p0_valid};
    assign cmd_v    = {p1_cmd, p0_cmd};
    assign addr_v   = {p1_addr, p0_addr};
    assign sz_v     = {p1_sz, p0_sz};
    assign op_v     = {p1_op, p0_op};
    assign din_v    = {p1_din, p0_din};
    assign rready_v = {p1_rready, p0_rready};

    // Writes need room in the controller FIFO, reads need a free tag slot.
    always_comb begin
        ok_v = '0;
        for (int n = 0; n < NPORT; n++) begin
            if (is_write(cmd_v[n])) begin
                ok_v[n] = ({1'b0, ctl_fillcount} +
                           {1'b0, cmd_beats(cmd_v[n], sz_v[n])}) <= FILL_LIMIT;
            end else if (is_read(cmd_v[n])) begin
                ok_v[n] = !tag_full;
            end
        end
    end

    assign elig_v    = valid_v & ok_v;
    assign win       = elig_v[1] && (!elig_v[0] || !ptr_q);
    assign win_beats = cmd_beats(cmd_v[win], sz_v[win]);
    assign issue     = !reset && (state_q == ST_IDLE) && ctl_ready &&
                       ctl_notfull && (|elig_v);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        bport_d  = bport_q;
        cnt_d    = cnt_q;
        ctl_cmd  = CMD_NOP;
        ctl_addr = '0;
        ctl_sz   = '0;
        ctl_op   = '0;
        ctl_din  = '0;
        accept_v = '0;
        wready_v = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    ctl_cmd       = cmd_v[win];
                    ctl_addr      = addr_v[win];
                    ctl_sz        = sz_v[win];
                    ctl_op        = op_v[win];
                    ctl_din       = din_v[win];
                    accept_v[win] = 1'b1;
                    ptr_d         = win;
                    if (cmd_v[win] == CMD_BLW) begin
                        state_d = ST_BURST;
                        bport_d = win;
                        cnt_d   = 5'(win_beats - 6'd1);
                    end
                end
            end
            ST_BURST: begin
                ctl_din           = din_v[bport_q];
                wready_v[bport_q] = 1'b1;
                cnt_d             = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A read just taken leaves ctl_validout stale for one cycle.
    assign ret_ok   = ctl_validout && !tag_empty && !rblk_q;
    assign ctl_read = ret_ok && rready_v[tag_head.port];
    assign tag_pop  = ctl_read && ((used_q + 6'd1) == tag_head.words);
    assign tag_push = issue && is_read(cmd_v[win]);
    assign tag_in   = '{port: win, words: win_beats};

    always_comb begin
        rvalid_v = '0;
        for (int n = 0; n < NPORT; n++) begin
            rvalid_v[n] = ret_ok && (tag_head.port == 1'(n));
        end
    end

    always_comb begin
        used_d = used_q;
        if (tag_pop) begin
            used_d = '0;
        end else if (ctl_read) begin
            used_d = used_q + 6'd1;
        end
    end

    assign p0_accept = accept_v[0];
    assign p1_accept = accept_v[1];
    assign p0_wready = wready_v[0];
    assign p1_wready = wready_v[1];
    assign p0_rvalid = rvalid_v[0];
    assign p1_rvalid = rvalid_v[1];
    assign p0_rdata  = rvalid_v[0] ? ctl_dout : '0;
    assign p1_rdata  = rvalid_v[1] ? ctl_dout : '0;
    assign p0_raddr  = rvalid_v[0] ? ctl_raddr : '0;
    assign p1_raddr  = rvalid_v[1] ? ctl_raddr : '0;

    ddr3_port_arbiter_fifo #(
        .DEPTH_P2 (TAG_DEPTH_P2),
        .WIDTH    (TAG_W)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tag_push),
        .din_i   (tag_in),
        .pop_i   (tag_pop),
        .dout_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b1;
            bport_q <= 1'b0;
            cnt_q   <= '0;
            used_q  <= '0;
            rblk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bport_q <= bport_d;
            cnt_q   <= cnt_d;
            used_q  <= used_d;
            rblk_q  <= ctl_read;
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Bench for ddr3_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ddr3_port_arbiter;

    localparam int TAGD = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_valid, p1_valid;
    logic [2:0]  p0_cmd, p1_cmd, p0_op, p1_op;
    logic [25:0] p0_addr, p1_addr;
    logic [1:0]  p0_sz, p1_sz;
    logic [15:0] p0_din, p1_din;
    logic        p0_accept, p1_accept, p0_wready, p1_wready;
    logic        p0_rvalid, p1_rvalid, p0_rready, p1_rready;
    logic [15:0] p0_rdata, p1_rdata;
    logic [25:0] p0_raddr, p1_raddr;
    logic [2:0]  ctl_cmd, ctl_op;
    logic [25:0] ctl_addr, ctl_raddr;
    logic [1:0]  ctl_sz;
    logic [15:0] ctl_din, ctl_dout;
    logic        ctl_read, ctl_ready, ctl_notfull, ctl_validout;
    logic [5:0]  ctl_fillcount;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.TAG_DEPTH_P2(4), .NPORT(2)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_cmd(p0_cmd), .p0_addr(p0_addr),
        .p0_sz(p0_sz), .p0_op(p0_op), .p0_din(p0_din),
        .p0_accept(p0_accept), .p0_wready(p0_wready),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_raddr(p0_raddr), .p0_rready(p0_rready),
        .p1_valid(p1_valid), .p1_cmd(p1_cmd), .p1_addr(p1_addr),
        .p1_sz(p1_sz), .p1_op(p1_op), .p1_din(p1_din),
        .p1_accept(p1_accept), .p1_wready(p1_wready),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_raddr(p1_raddr), .p1_rready(p1_rready),
        .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr), .ctl_sz(ctl_sz),
        .ctl_op(ctl_op), .ctl_din(ctl_din), .ctl_read(ctl_read),
        .ctl_ready(ctl_ready), .ctl_notfull(ctl_notfull),
        .ctl_validout(ctl_validout), .ctl_fillcount(ctl_fillcount),
        .ctl_dout(ctl_dout), .ctl_raddr(ctl_raddr)
    );

    typedef struct {
        logic        v0, v1;
        logic [2:0]  c0, c1;
        logic [1:0]  s0, s1;
        logic        rdy, nf, vo;
        logic [5:0]  fill;
        logic [1:0]  acc;
        logic [2:0]  cmd;
        logic [15:0] din;
        logic        rd;
    } vec_t;

    vec_t tbl [13];

    typedef struct {
        int port;
        int words;
    } tag_s;

    tag_s mq[$];
    int   m_burst, m_bport, m_ptr, m_used, m_blk;
    int   v[2], c[2], s[2], win, rp, w, prev;
    bit   ok[2], rv, do_push;
    logic [1:0]  e_acc, e_wr, e_rv;
    logic [2:0]  e_cmd;
    logic        e_rd;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic defaults();
        p0_valid = 0; p1_valid = 0;
        p0_cmd = 0; p1_cmd = 0;
        p0_sz = 0; p1_sz = 0;
        p0_op = 3'd1; p1_op = 3'd2;
        p0_addr = 26'h0AAAAAA; p1_addr = 26'h1555555;
        p0_din = 16'hA0A0; p1_din = 16'hB1B1;
        p0_rready = 1; p1_rready = 1;
        ctl_ready = 1; ctl_notfull = 1; ctl_validout = 0;
        ctl_fillcount = 0; ctl_dout = 0; ctl_raddr = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        defaults();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    function automatic int nbeats(int cc, int ss);
        return (cc == 3 || cc == 4) ? (ss + 1) * 8 : 1;
    endfunction

    function automatic bit is_wr(int cc);
        return cc == 2 || cc == 4 || cc == 6;
    endfunction

    function automatic bit is_rd(int cc);
        return cc == 1 || cc == 3 || cc == 5;
    endfunction

    initial begin
        defaults();

        // Single-cycle decisions from the reset state (pointer favours p0).
        tbl[0]  = '{1,0, 2,0, 0,0, 1,1,0,  0, 2'b01, 2, 16'hA0A0, 0};
        tbl[1]  = '{1,1, 2,2, 0,0, 1,1,0,  0, 2'b01, 2, 16'hA0A0, 0};
        tbl[2]  = '{0,1, 0,1, 0,0, 1,1,0,  0, 2'b10, 1, 16'hB1B1, 0};
        tbl[3]  = '{1,1, 2,2, 0,0, 0,1,0,  0, 2'b00, 0, 16'h0000, 0};
        tbl[4]  = '{1,1, 2,2, 0,0, 1,0,0,  0, 2'b00, 0, 16'h0000, 0};
        tbl[5]  = '{1,1, 4,2, 1,0, 1,1,0, 20, 2'b10, 2, 16'hB1B1, 0};
        tbl[6]  = '{1,0, 4,0, 1,0, 1,1,0, 16, 2'b01, 4, 16'hA0A0, 0};
        tbl[7]  = '{1,0, 2,0, 0,0, 1,1,0, 31, 2'b01, 2, 16'hA0A0, 0};
        tbl[8]  = '{1,0, 6,0, 0,0, 1,1,0, 32, 2'b00, 0, 16'h0000, 0};
        tbl[9]  = '{1,1, 1,6, 0,0, 1,1,0, 32, 2'b01, 1, 16'hA0A0, 0};
        tbl[10] = '{1,1, 3,5, 3,0, 1,1,1, 63, 2'b01, 3, 16'hA0A0, 0};
        tbl[11] = '{1,1, 4,6, 0,0, 1,1,1, 25, 2'b10, 6, 16'hB1B1, 0};
        tbl[12] = '{0,1, 0,2, 0,0, 1,1,0, 63, 2'b00, 0, 16'h0000, 0};

        do_reset();
        reset = 1;
        p0_valid = 1; p0_cmd = 2; p1_valid = 1; p1_cmd = 2;
        ctl_validout = 1;
        #1;
        chk("reset_out", {p0_accept, p1_accept, p0_wready, p1_wready,
                          p0_rvalid, p1_rvalid, ctl_read, ctl_cmd}, '0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            p0_valid = tbl[i].v0; p1_valid = tbl[i].v1;
            p0_cmd = tbl[i].c0; p1_cmd = tbl[i].c1;
            p0_sz = tbl[i].s0; p1_sz = tbl[i].s1;
            ctl_ready = tbl[i].rdy; ctl_notfull = tbl[i].nf;
            ctl_validout = tbl[i].vo; ctl_fillcount = tbl[i].fill;
            settle();
            chk($sformatf("vec%0d", i),
                {p1_accept, p0_accept, ctl_cmd,
                 (ctl_cmd != 0) ? ctl_din : 16'h0,
                 ctl_read, p1_rvalid, p0_rvalid},
                {tbl[i].acc, tbl[i].cmd, tbl[i].din, tbl[i].rd, 2'b00});
        end

        // Both ports streaming single writes alternate.
        do_reset();
        p0_valid = 1; p0_cmd = 2; p1_valid = 1; p1_cmd = 2;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("alternate", {p1_accept, p0_accept, ctl_din},
                (k % 2) ? {2'b10, 16'hB1B1} : {2'b01, 16'hA0A0});
            tick();
        end

        // 16-beat write burst holds off the other port.
        do_reset();
        p0_valid = 1; p0_cmd = 4; p0_sz = 1; p0_din = 16'h0100;
        p1_valid = 1; p1_cmd = 2;
        settle();
        chk("blw_issue", {p1_accept, p0_accept, ctl_cmd, ctl_din},
            {2'b01, 3'd4, 16'h0100});
        for (int k = 1; k < 16; k++) begin
            tick();
            p0_din = 16'h0100 + 16'(k);
            settle();
            chk("blw_beat", {p0_wready, p1_accept, ctl_cmd, ctl_din},
                {1'b1, 1'b0, 3'd0, 16'h0100 + 16'(k)});
        end
        tick();
        p0_valid = 0;
        settle();
        chk("blw_done", {p0_wready, p1_accept, ctl_cmd}, {1'b0, 1'b1, 3'd2});

        // Full controller FIFO defers the burst but not the single write.
        do_reset();
        ctl_fillcount = 20;
        p0_valid = 1; p0_cmd = 4; p0_sz = 1;
        p1_valid = 1; p1_cmd = 2;
        settle();
        chk("fill_p1", {p1_accept, p0_accept}, 2'b10);
        tick();
        p1_valid = 0;
        settle();
        chk("fill_wait20", {p1_accept, p0_accept}, 2'b00);
        tick();
        ctl_fillcount = 17;
        settle();
        chk("fill_wait17", {p1_accept, p0_accept}, 2'b00);
        tick();
        ctl_fillcount = 16;
        settle();
        chk("fill_go16", {p1_accept, p0_accept, ctl_cmd}, {2'b01, 3'd4});

        // Nine returned words split 8 to p0, 1 to p1, never back-to-back.
        do_reset();
        p0_valid = 1; p0_cmd = 3; p0_sz = 0;
        settle();
        chk("rd_issue0", {p1_accept, p0_accept, ctl_cmd}, {2'b01, 3'd3});
        tick();
        p0_valid = 0; p1_valid = 1; p1_cmd = 1;
        settle();
        chk("rd_issue1", {p1_accept, p0_accept, ctl_cmd}, {2'b10, 3'd1});
        tick();
        p1_valid = 0;
        ctl_validout = 1; ctl_dout = 16'h5000; ctl_raddr = 0;
        w = 0; prev = 0;
        for (int cyc = 0; cyc < 40 && w < 9; cyc++) begin
            settle();
            chk("ret_other", (w < 8) ? p1_rvalid : p0_rvalid, 0);
            chk("ret_gap", ctl_read && prev, 0);
            if (ctl_read) begin
                chk("ret_data",
                    (w < 8) ? {p0_rvalid, p0_rdata, p0_raddr}
                            : {p1_rvalid, p1_rdata, p1_raddr},
                    {1'b1, 16'h5000 + 16'(w), 26'(w)});
                w++;
            end
            prev = ctl_read;
            tick();
            ctl_dout = 16'h5000 + 16'(w);
            ctl_raddr = 26'(w);
        end
        chk("ret_count", w, 9);
        tick();
        settle();
        chk("ret_empty", {ctl_read, p0_rvalid, p1_rvalid}, 3'b000);

        // Reset in the middle of a burst with a read tag outstanding.
        do_reset();
        p1_valid = 1; p1_cmd = 1;
        settle();
        chk("mid_rd", {p1_accept, p0_accept}, 2'b10);
        tick();
        p1_valid = 0;
        p0_valid = 1; p0_cmd = 4; p0_sz = 1;
        settle();
        chk("mid_blw", {p1_accept, p0_accept, ctl_cmd}, {2'b01, 3'd4});
        for (int k = 1; k <= 5; k++) begin
            tick();
            settle();
        end
        chk("mid_beat5", p0_wready, 1'b1);
        p1_valid = 1; p1_cmd = 2;
        ctl_validout = 1;
        reset = 1;
        #1;
        chk("mid_rst_a", {p0_accept, p0_wready, p0_rvalid, p0_rdata, p0_raddr,
                          p1_accept, p1_wready, p1_rvalid, p1_rdata, p1_raddr},
            '0);
        chk("mid_rst_b", {ctl_cmd, ctl_addr, ctl_sz, ctl_op, ctl_din, ctl_read},
            '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        p0_cmd = 2; p0_sz = 0;
        settle();
        chk("mid_after", {p1_accept, p0_accept, ctl_cmd, p1_rvalid, p0_rvalid,
                          ctl_read}, {2'b01, 3'd2, 3'b000});

        // Blocked issue leaves the pointer where it was.
        do_reset();
        p0_valid = 1; p0_cmd = 2; p1_valid = 1; p1_cmd = 2;
        ctl_notfull = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("nf_block", {p1_accept, p0_accept, ctl_cmd}, '0);
            tick();
        end
        ctl_notfull = 1;
        settle();
        chk("nf_p0", {p1_accept, p0_accept}, 2'b01);
        tick();
        ctl_notfull = 0;
        settle();
        chk("nf_block2", {p1_accept, p0_accept, ctl_cmd}, '0);
        tick();
        ctl_notfull = 1;
        settle();
        chk("nf_p1", {p1_accept, p0_accept}, 2'b10);

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        m_burst = 0; m_bport = 0; m_ptr = 1; m_used = 0; m_blk = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            p0_valid = ($urandom_range(0, 3) != 0);
            p1_valid = ($urandom_range(0, 3) != 0);
            p0_cmd = 3'($urandom_range(1, 6));
            p1_cmd = 3'($urandom_range(1, 6));
            p0_sz = 2'($urandom); p1_sz = 2'($urandom);
            p0_op = 3'($urandom); p1_op = 3'($urandom);
            p0_addr = 26'($urandom); p1_addr = 26'($urandom);
            p0_din = 16'($urandom); p1_din = 16'($urandom);
            p0_rready = ($urandom_range(0, 3) != 0);
            p1_rready = ($urandom_range(0, 3) != 0);
            ctl_ready = ($urandom_range(0, 4) != 0);
            ctl_notfull = ($urandom_range(0, 4) != 0);
            ctl_validout = 1'($urandom_range(0, 1));
            ctl_fillcount = 6'($urandom_range(0, 40));
            ctl_dout = 16'($urandom); ctl_raddr = 26'($urandom);
            settle();

            v[0] = p0_valid; v[1] = p1_valid;
            c[0] = p0_cmd;   c[1] = p1_cmd;
            s[0] = p0_sz;    s[1] = p1_sz;
            win = -1;
            if (m_burst == 0 && ctl_ready && ctl_notfull) begin
                for (int n = 0; n < 2; n++) begin
                    ok[n] = v[n] != 0 &&
                        (is_wr(c[n]) ? (int'(ctl_fillcount) + nbeats(c[n], s[n]) <= 32)
                                     : (is_rd(c[n]) && mq.size() < TAGD));
                end
                if (ok[0] && ok[1]) win = 1 - m_ptr;
                else if (ok[0]) win = 0;
                else if (ok[1]) win = 1;
            end
            e_acc = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
            e_cmd = (win >= 0) ? 3'(c[win]) : 3'd0;
            e_wr  = (m_burst > 0) ? ((m_bport == 1) ? 2'b10 : 2'b01) : 2'b00;
            rv = ctl_validout && mq.size() > 0 && m_blk == 0;
            rp = rv ? mq[0].port : 0;
            e_rv = rv ? ((rp == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_rd = rv && ((rp == 1) ? p1_rready : p0_rready);

            chk("rnd_ctl", {p1_accept, p0_accept, ctl_cmd, p1_wready, p0_wready,
                            p1_rvalid, p0_rvalid, ctl_read},
                {e_acc, e_cmd, e_wr, e_rv, e_rd});
            if (win == 0)
                chk("rnd_fld0", {ctl_addr, ctl_sz, ctl_op, ctl_din},
                    {p0_addr, p0_sz, p0_op, p0_din});
            if (win == 1)
                chk("rnd_fld1", {ctl_addr, ctl_sz, ctl_op, ctl_din},
                    {p1_addr, p1_sz, p1_op, p1_din});
            if (m_burst > 0)
                chk("rnd_bdin", ctl_din, (m_bport == 1) ? p1_din : p0_din);
            if (rv)
                chk("rnd_ret", (rp == 1) ? {p1_rdata, p1_raddr} : {p0_rdata, p0_raddr},
                    {ctl_dout, ctl_raddr});

            do_push = 0;
            if (m_burst > 0) begin
                m_burst--;
            end else if (win >= 0) begin
                m_ptr = win;
                if (c[win] == 4) begin
                    m_burst = nbeats(c[win], s[win]) - 1;
                    m_bport = win;
                end
                do_push = is_rd(c[win]);
            end
            if (e_rd) begin
                m_used++;
                if (m_used == mq[0].words) begin
                    void'(mq.pop_front());
                    m_used = 0;
                end
            end
            if (do_push) mq.push_back('{win, nbeats(c[win], s[win])});
            m_blk = e_rd;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
